// File: rtl/cond_flag_unit_if.sv
// Execute-stage bus for cond_flag_unit: instruction controls and ALU outputs in,
// condition result, flag register and memory-stage pipeline register out.
interface cond_flag_unit_if #(
    parameter int WIDTH = 32,
    parameter int RA_W  = 4
);
    logic             Stall;
    logic             Flush;
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS;
    logic             RegW;
    logic             MemW;
    logic             NoWrite;
    logic [WIDTH-1:0] ALUResult;
    logic [RA_W-1:0]  WA3;
    logic             CondEx;
    logic [3:0]       Flags;
    logic             PCSrcM;
    logic             RegWriteM;
    logic             MemWriteM;
    logic [WIDTH-1:0] ALUResultM;
    logic [RA_W-1:0]  WA3M;
    logic [31:0]      SquashCount;

    modport master (
        output Stall, Flush, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, ALUResult, WA3,
        input  CondEx, Flags, PCSrcM, RegWriteM, MemWriteM, ALUResultM, WA3M, SquashCount
    );

    modport slave (
        input  Stall, Flush, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, ALUResult, WA3,
        output CondEx, Flags, PCSrcM, RegWriteM, MemWriteM, ALUResultM, WA3M, SquashCount
    );
endinterface

// File: rtl/cond_flag_unit.sv
// NZCV flag register, ARM condition evaluation and execute/memory pipeline register.
// Optional squashed-instruction counter enabled by defining COND_FLAG_SQUASH_CNT_EN.
module cond_flag_unit #(
    parameter int WIDTH = 32,
    parameter int RA_W  = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    cond_flag_unit_if.slave bus
);

    // Flags are {N,Z,C,V}; condition is evaluated against the flags before this instruction.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n;
        logic z;
        logic c;
        logic v;
        logic r;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            4'b0000: r = z;
            4'b0001: r = ~z;
            4'b0010: r = c;
            4'b0011: r = ~c;
            4'b0100: r = n;
            4'b0101: r = ~n;
            4'b0110: r = v;
            4'b0111: r = ~v;
            4'b1000: r = c & ~z;
            4'b1001: r = ~c | z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = ~z & (n == v);
            4'b1101: r = z | (n != v);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    logic [3:0]       flags_q,  flags_d;
    logic             pcsrc_q,  pcsrc_d;
    logic             regw_q,   regw_d;
    logic             memw_q,   memw_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [RA_W-1:0]  wa3_q,    wa3_d;

    logic cond_ex_s;
    logic pcs_g_s;
    logic reg_g_s;
    logic mem_g_s;
    logic flag_upd_s;

    // Condition evaluation and write-enable gating.
    always_comb begin
        cond_ex_s  = cond_pass(bus.Cond, flags_q);
        pcs_g_s    = bus.PCS & cond_ex_s;
        reg_g_s    = bus.RegW & ~bus.NoWrite & cond_ex_s;
        mem_g_s    = bus.MemW & cond_ex_s;
        flag_upd_s = cond_ex_s & ~bus.Stall & ~bus.Flush;
    end

    // Next-state for flags and pipeline register; Flush outranks Stall.
    always_comb begin
        flags_d  = flags_q;
        pcsrc_d  = pcsrc_q;
        regw_d   = regw_q;
        memw_d   = memw_q;
        result_d = result_q;
        wa3_d    = wa3_q;
        if (flag_upd_s) begin
            if (bus.FlagW[1]) begin
                flags_d[3:2] = bus.ALUFlags[3:2];
            end else begin
                flags_d[3:2] = flags_q[3:2];
            end
            if (bus.FlagW[0]) begin
                flags_d[1:0] = bus.ALUFlags[1:0];
            end else begin
                flags_d[1:0] = flags_q[1:0];
            end
        end else begin
            flags_d = flags_q;
        end
        if (bus.Flush) begin
            pcsrc_d  = 1'b0;
            regw_d   = 1'b0;
            memw_d   = 1'b0;
            result_d = {WIDTH{1'b0}};
            wa3_d    = {RA_W{1'b0}};
        end else if (bus.Stall) begin
            pcsrc_d  = pcsrc_q;
            regw_d   = regw_q;
            memw_d   = memw_q;
            result_d = result_q;
            wa3_d    = wa3_q;
        end else begin
            pcsrc_d  = pcs_g_s;
            regw_d   = reg_g_s;
            memw_d   = mem_g_s;
            result_d = bus.ALUResult;
            wa3_d    = bus.WA3;
        end
    end

    // Flag and pipeline state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q  <= 4'b0000;
            pcsrc_q  <= 1'b0;
            regw_q   <= 1'b0;
            memw_q   <= 1'b0;
            result_q <= {WIDTH{1'b0}};
            wa3_q    <= {RA_W{1'b0}};
        end else begin
            flags_q  <= flags_d;
            pcsrc_q  <= pcsrc_d;
            regw_q   <= regw_d;
            memw_q   <= memw_d;
            result_q <= result_d;
            wa3_q    <= wa3_d;
        end
    end

`ifdef COND_FLAG_SQUASH_CNT_EN
    logic [31:0] squash_q, squash_d;

    // Count instructions that would have written something but failed their condition.
    always_comb begin
        if (~cond_ex_s & ~bus.Stall & ~bus.Flush & (bus.PCS | bus.RegW | bus.MemW)) begin
            squash_d = squash_q + 32'd1;
        end else begin
            squash_d = squash_q;
        end
    end

    // Squash counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            squash_q <= 32'd0;
        end else begin
            squash_q <= squash_d;
        end
    end

    assign bus.SquashCount = squash_q;
`else
    assign bus.SquashCount = 32'd0;
`endif

    assign bus.CondEx     = cond_ex_s;
    assign bus.Flags      = flags_q;
    assign bus.PCSrcM     = pcsrc_q;
    assign bus.RegWriteM  = regw_q;
    assign bus.MemWriteM  = memw_q;
    assign bus.ALUResultM = result_q;
    assign bus.WA3M       = wa3_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Table-driven bench for cond_flag_unit with a queue of expected memory-stage results.
module tb_cond_flag_unit;

    logic clk;
    logic reset_n;

    cond_flag_unit_if #(.WIDTH(32), .RA_W(4)) bus ();

    cond_flag_unit #(.WIDTH(32), .RA_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        st;
        logic        fl;
        logic [3:0]  cond;
        logic [3:0]  af;
        logic [1:0]  fw;
        logic        pcs;
        logic        rw;
        logic        mw;
        logic        nw;
        logic [31:0] res;
        logic [3:0]  wa;
        logic        x_cx;
        logic [3:0]  x_flags;
        logic        x_pc;
        logic        x_rw;
        logic        x_mw;
        logic [31:0] x_res;
        logic [3:0]  x_wa;
        logic        sq;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];
    vec_t sb_q [$];
    vec_t exp_v;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_sq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.Stall = 1'b0; bus.Flush = 1'b0; bus.Cond = 4'h0; bus.ALUFlags = 4'h0;
        bus.FlagW = 2'b00; bus.PCS = 1'b0; bus.RegW = 1'b0; bus.MemW = 1'b0;
        bus.NoWrite = 1'b0; bus.ALUResult = 32'h0; bus.WA3 = 4'h0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_Flags"}, {28'h0, bus.Flags}, 32'h0);
        chk({tag, "_PCSrcM"}, {31'h0, bus.PCSrcM}, 32'h0);
        chk({tag, "_RegWriteM"}, {31'h0, bus.RegWriteM}, 32'h0);
        chk({tag, "_MemWriteM"}, {31'h0, bus.MemWriteM}, 32'h0);
        chk({tag, "_ALUResultM"}, bus.ALUResultM, 32'h0);
        chk({tag, "_WA3M"}, {28'h0, bus.WA3M}, 32'h0);
        chk({tag, "_SquashCount"}, bus.SquashCount, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //            st    fl    cond   af     fw     pcs   rw    mw    nw    res            wa      cx    flags  pc    rw    mw    res            wa      sq
        vecs[0]  = '{1'b0,1'b0,4'hE,4'h4,2'b11,1'b0,1'b1,1'b0,1'b0,32'h0000_0000,4'd3,  1'b1,4'h4,1'b0,1'b1,1'b0,32'h0000_0000,4'd3,  1'b0};
        vecs[1]  = '{1'b0,1'b0,4'h0,4'h0,2'b00,1'b0,1'b0,1'b1,1'b0,32'h0000_0011,4'd5,  1'b1,4'h4,1'b0,1'b0,1'b1,32'h0000_0011,4'd5,  1'b0};
        vecs[2]  = '{1'b0,1'b0,4'h1,4'h8,2'b11,1'b1,1'b1,1'b0,1'b0,32'h0000_0022,4'd6,  1'b0,4'h4,1'b0,1'b0,1'b0,32'h0000_0022,4'd6,  1'b1};
        vecs[3]  = '{1'b0,1'b0,4'hE,4'h9,2'b11,1'b0,1'b1,1'b0,1'b1,32'h0000_0033,4'd7,  1'b1,4'h9,1'b0,1'b0,1'b0,32'h0000_0033,4'd7,  1'b0};
        vecs[4]  = '{1'b0,1'b0,4'hA,4'h0,2'b00,1'b0,1'b0,1'b1,1'b0,32'h0000_0044,4'd8,  1'b1,4'h9,1'b0,1'b0,1'b1,32'h0000_0044,4'd8,  1'b0};
        vecs[5]  = '{1'b0,1'b0,4'hC,4'h0,2'b00,1'b1,1'b0,1'b0,1'b0,32'h0000_0055,4'd9,  1'b1,4'h9,1'b1,1'b0,1'b0,32'h0000_0055,4'd9,  1'b0};
        vecs[6]  = '{1'b0,1'b0,4'hE,4'h6,2'b01,1'b0,1'b1,1'b0,1'b0,32'h0000_0066,4'd10, 1'b1,4'hA,1'b0,1'b1,1'b0,32'h0000_0066,4'd10, 1'b0};
        vecs[7]  = '{1'b0,1'b0,4'hA,4'h0,2'b11,1'b0,1'b1,1'b0,1'b0,32'h0000_0077,4'd11, 1'b0,4'hA,1'b0,1'b0,1'b0,32'h0000_0077,4'd11, 1'b1};
        vecs[8]  = '{1'b0,1'b0,4'hB,4'h0,2'b00,1'b0,1'b1,1'b0,1'b0,32'h0000_0088,4'd12, 1'b1,4'hA,1'b0,1'b1,1'b0,32'h0000_0088,4'd12, 1'b0};
        vecs[9]  = '{1'b1,1'b0,4'hE,4'hF,2'b11,1'b0,1'b1,1'b0,1'b0,32'hDEAD_BEEF,4'd13, 1'b1,4'hA,1'b0,1'b1,1'b0,32'h0000_0088,4'd12, 1'b0};
        vecs[10] = '{1'b0,1'b0,4'h0,4'h0,2'b00,1'b0,1'b0,1'b0,1'b0,32'h0000_0099,4'd14, 1'b0,4'hA,1'b0,1'b0,1'b0,32'h0000_0099,4'd14, 1'b0};
        vecs[11] = '{1'b1,1'b1,4'hE,4'hF,2'b11,1'b1,1'b1,1'b1,1'b0,32'h0000_00CC,4'd1,  1'b1,4'hA,1'b0,1'b0,1'b0,32'h0000_0000,4'd0,  1'b0};
        vecs[12] = '{1'b0,1'b1,4'h0,4'hF,2'b11,1'b0,1'b1,1'b0,1'b0,32'h0000_00DD,4'd2,  1'b0,4'hA,1'b0,1'b0,1'b0,32'h0000_0000,4'd0,  1'b0};
        vecs[13] = '{1'b1,1'b0,4'h0,4'h0,2'b00,1'b0,1'b1,1'b0,1'b0,32'h0000_00EE,4'd3,  1'b0,4'hA,1'b0,1'b0,1'b0,32'h0000_0000,4'd0,  1'b0};
        vecs[14] = '{1'b0,1'b0,4'hF,4'hF,2'b11,1'b1,1'b1,1'b1,1'b0,32'hAAAA_5555,4'd15, 1'b1,4'hF,1'b1,1'b1,1'b1,32'hAAAA_5555,4'd15, 1'b0};
        vecs[15] = '{1'b0,1'b0,4'h8,4'h0,2'b00,1'b0,1'b0,1'b1,1'b0,32'h0000_005A,4'd4,  1'b0,4'hF,1'b0,1'b0,1'b0,32'h0000_005A,4'd4,  1'b1};
        vecs[16] = '{1'b0,1'b0,4'hD,4'h0,2'b00,1'b0,1'b1,1'b0,1'b0,32'h0000_00A5,4'd5,  1'b1,4'hF,1'b0,1'b1,1'b0,32'h0000_00A5,4'd5,  1'b0};

        exp_sq  = 32'd0;
        reset_n = 1'b0;
        idle_inputs();
        #1;
        check_all_zero("reset_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("reset_idle");
        bus.Cond = 4'hE;
        #1;
        chk("idle_condex_AL", {31'h0, bus.CondEx}, 32'h1);
        bus.Cond = 4'h0;
        #1;
        chk("idle_condex_EQ", {31'h0, bus.CondEx}, 32'h0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            bus.Stall     = vecs[i].st;
            bus.Flush     = vecs[i].fl;
            bus.Cond      = vecs[i].cond;
            bus.ALUFlags  = vecs[i].af;
            bus.FlagW     = vecs[i].fw;
            bus.PCS       = vecs[i].pcs;
            bus.RegW      = vecs[i].rw;
            bus.MemW      = vecs[i].mw;
            bus.NoWrite   = vecs[i].nw;
            bus.ALUResult = vecs[i].res;
            bus.WA3       = vecs[i].wa;
            #1;
            chk($sformatf("v%0d_CondEx", i), {31'h0, bus.CondEx}, {31'h0, vecs[i].x_cx});
            sb_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            exp_v = sb_q.pop_front();
`ifdef COND_FLAG_SQUASH_CNT_EN
            if (exp_v.sq) exp_sq = exp_sq + 32'd1;
`endif
            chk($sformatf("v%0d_Flags", i), {28'h0, bus.Flags}, {28'h0, exp_v.x_flags});
            chk($sformatf("v%0d_PCSrcM", i), {31'h0, bus.PCSrcM}, {31'h0, exp_v.x_pc});
            chk($sformatf("v%0d_RegWriteM", i), {31'h0, bus.RegWriteM}, {31'h0, exp_v.x_rw});
            chk($sformatf("v%0d_MemWriteM", i), {31'h0, bus.MemWriteM}, {31'h0, exp_v.x_mw});
            chk($sformatf("v%0d_ALUResultM", i), bus.ALUResultM, exp_v.x_res);
            chk($sformatf("v%0d_WA3M", i), {28'h0, bus.WA3M}, {28'h0, exp_v.x_wa});
            chk($sformatf("v%0d_SquashCount", i), bus.SquashCount, exp_sq);
        end

        chk("pre_reset_RegWriteM", {31'h0, bus.RegWriteM}, 32'h1);
        chk("pre_reset_Flags", {28'h0, bus.Flags}, 32'hF);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset_Flags", {28'h0, bus.Flags}, 32'h0);
        chk("midreset_PCSrcM", {31'h0, bus.PCSrcM}, 32'h0);
        chk("midreset_RegWriteM", {31'h0, bus.RegWriteM}, 32'h0);
        chk("midreset_MemWriteM", {31'h0, bus.MemWriteM}, 32'h0);
        chk("midreset_ALUResultM", bus.ALUResultM, 32'h0);
        chk("midreset_WA3M", {28'h0, bus.WA3M}, 32'h0);
        chk("midreset_SquashCount", bus.SquashCount, 32'h0);
        chk("scoreboard_empty", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cond_flag_unit.md
Name: cond_flag_unit

Overview:
- Execute-stage consumer of the ALU's Result and ALUFlags outputs.
- Holds the architectural NZCV flag register and evaluates the ARM 4-bit condition field against it.
- Gates the instruction's write enables on the condition result and registers the gated controls plus the ALU result into the execute/memory pipeline register.
- Supports stall and flush from the hazard unit.

Parameters:
- WIDTH, 32, width of the ALU result datapath.
- RA_W, 4, width of the destination register address.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- Stall  input  1  hold the pipeline register and flags
- Flush  input  1  insert a bubble into the memory stage
- Cond  input  4  instruction condition field
- ALUFlags  input  4  {N,Z,C,V} from the ALU for the current instruction
- FlagW  input  2  bit1 = update N,Z; bit0 = update C,V
- PCS  input  1  instruction writes the PC
- RegW  input  1  instruction writes the register file
- MemW  input  1  instruction writes memory
- NoWrite  input  1  compare-type instruction; suppresses RegW
- ALUResult  input  WIDTH  ALU Result
- WA3  input  RA_W  destination register
- CondEx  output  1  combinational condition-pass for the current instruction
- Flags  output  4  current registered {N,Z,C,V}
- PCSrcM  output  1  registered gated PCS
- RegWriteM  output  1  registered gated RegW
- MemWriteM  output  1  registered gated MemW
- ALUResultM  output  WIDTH  registered ALUResult
- WA3M  output  RA_W  registered WA3
- SquashCount  output  32  squashed-instruction count (see Optional Feature)

Behaviour:
- Reset (reset_n low, asynchronous):
  - Flags, PCSrcM, RegWriteM, MemWriteM, ALUResultM, WA3M and SquashCount all clear to 0.
  - Reset asserted mid-operation discards the in-flight stage contents immediately.
  - The first capture occurs on the first rising edge after reset_n deasserts.
- CondEx is combinational from Cond and the registered Flags. It is never computed from ALUFlags (the flags seen are those before the current instruction's update). Condition codes:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C & !Z
  - 1001 LS: !C | Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z & (N==V)
  - 1101 LE: Z | (N!=V)
  - 1110 AL: 1
  - 1111: 1 (unconditional)
- Gating:
  - pcs_g = PCS & CondEx
  - reg_g = RegW & !NoWrite & CondEx
  - mem_g = MemW & CondEx
- Flag update at the clock edge, only when CondEx & !Stall & !Flush:
  - Flags[3:2] <= ALUFlags[3:2] if FlagW[1].
  - Flags[1:0] <= ALUFlags[1:0] if FlagW[0].
  - Bits not enabled hold their value.
- Pipeline register, priority Flush > Stall > normal:
  - Flush: PCSrcM, RegWriteM and MemWriteM go to 0; ALUResultM and WA3M go to 0; Flags hold.
  - Stall (no Flush): all registers hold, including Flags.
  - Normal: PCSrcM <= pcs_g, RegWriteM <= reg_g, MemWriteM <= mem_g, ALUResultM <= ALUResult, WA3M <= WA3.
- Latency: 1 cycle from inputs to the *M outputs. A flag update is visible on Flags and CondEx on the cycle after the update.
- Back-to-back dependence: a flag-setting instruction followed by a conditional instruction resolves correctly with no bubble, because the second instruction reads the registered flags.
- A failed condition still captures ALUResult and WA3, with all write controls 0.

Optional Feature:
- Macro: COND_FLAG_SQUASH_CNT_EN.
- Defined:
  - SquashCount is a 32-bit counter that increments at each edge where !CondEx & !Stall & !Flush & (PCS|RegW|MemW).
  - It wraps from 0xFFFFFFFF to 0 and clears on reset.
- Undefined: no counter logic is built and SquashCount is tied to 0.

Test Plan:
- Reset, then idle -> Flags = 0000, all *M = 0, CondEx = 1 for Cond = 1110 and 0 for Cond = 0000.
- Cond = 1110, FlagW = 11, ALUFlags = 0100 (result zero), RegW = 1, ALUResult = 0x0000_0000, WA3 = 3 -> next cycle: Flags = 0100, RegWriteM = 1, WA3M = 3. Following instruction with Cond = 0000 (EQ), MemW = 1 -> CondEx = 1, MemWriteM = 1.
- Flags = 0100, Cond = 0001 (NE), PCS = 1, RegW = 1, FlagW = 11, ALUFlags = 1000 -> PCSrcM = 0, RegWriteM = 0, Flags stay 0100; SquashCount increments by 1 when the macro is defined.
- Flags = 1001 (N=1, V=1): Cond = 1010 (GE) -> CondEx = 1; Cond = 1100 (GT) -> CondEx = 1. Then FlagW = 01, ALUFlags = 0110 -> Flags = 1010 (N,Z held; C,V updated), after which GE -> 0.
- Stall = 1 with new inputs (ALUResult = 0xDEAD_BEEF, FlagW = 11) -> *M and Flags unchanged. Stall = 1 and Flush = 1 together -> *M controls and data = 0, Flags unchanged.
- Assert reset_n = 0 mid-cycle while RegWriteM = 1 and Flags = 1111 -> all outputs 0 immediately, without waiting for a clock edge.
